// File: rtl/alu_cmd_sequencer.sv
// Command sequencer for an 8-bit combinational ALU: accepts operand/opcode
// commands, drives the ALU, waits a settle time and returns captured results.
module alu_cmd_sequencer #(
  parameter int WIDTH   = 8,
  parameter int SEL_W   = 3,
  parameter int NUM_OPS = 5,
  parameter int SETTLE  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [SEL_W-1:0] cmd_sel,
  input  logic             cmd_sweep,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [SEL_W-1:0] alu_sel,
  input  logic [WIDTH-1:0] alu_y,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_y,
  output logic [SEL_W-1:0] rsp_sel,
  output logic             rsp_last,
  output logic             busy
);

  localparam int               CNT_W     = $clog2(SETTLE + 1);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(SETTLE);
  localparam logic [SEL_W-1:0] LAST_SEL  = SEL_W'(NUM_OPS - 1);

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_e;

  state_e             state_q;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   b_q;
  logic [SEL_W-1:0]   sel_q;
  logic               sweep_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [WIDTH-1:0]   rsp_y_q;
  logic [SEL_W-1:0]   rsp_sel_q;
  logic               rsp_last_q;
  logic               rsp_valid_q;
  logic               cmd_ready_q;
  logic               busy_q;
  logic               last_d;

  // A single command ends after one op, or after the final opcode of a sweep.
  always_comb begin
    last_d = !sweep_q || (sel_q == LAST_SEL);
  end

  always_ff @(posedge clk) begin
    // NOTE: every register is cleared here, including the datapath, because
    // the ALU-facing and response outputs must read 0 while in reset.
    if (!rst_n) begin
      state_q     <= IDLE;
      a_q         <= '0;
      b_q         <= '0;
      sel_q       <= '0;
      sweep_q     <= 1'b0;
      cnt_q       <= '0;
      rsp_y_q     <= '0;
      rsp_sel_q   <= '0;
      rsp_last_q  <= 1'b0;
      rsp_valid_q <= 1'b0;
      cmd_ready_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments throughout, so every branch below sees
      // the pre-edge register values regardless of statement order.
      case (state_q)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            a_q         <= cmd_a;
            b_q         <= cmd_b;
            sweep_q     <= cmd_sweep;
            sel_q       <= cmd_sweep ? '0 : cmd_sel;
            cnt_q       <= SETTLE_LD;
            cmd_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            state_q     <= DRIVE;
          end
        end

        DRIVE: begin
          cnt_q <= cnt_q - 1'b1;
          if (cnt_q == CNT_W'(1)) begin
            rsp_y_q     <= alu_y;
            rsp_sel_q   <= sel_q;
            rsp_last_q  <= last_d;
            rsp_valid_q <= 1'b1;
            state_q     <= RESP;
          end
        end

        RESP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            if (!rsp_last_q) begin
              sel_q   <= sel_q + 1'b1;
              cnt_q   <= SETTLE_LD;
              state_q <= DRIVE;
            end else begin
              busy_q      <= 1'b0;
              cmd_ready_q <= 1'b1;
              state_q     <= IDLE;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign alu_a     = a_q;
  assign alu_b     = b_q;
  assign alu_sel   = sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_sel   = rsp_sel_q;
  assign rsp_last  = rsp_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_alu_cmd_sequencer.sv
// Bench for alu_cmd_sequencer: scoreboard-checked random and directed traffic
// on a SETTLE=1 instance plus directed settle/wrap checks on a SETTLE=3 one.
module tb_alu_cmd_sequencer;

  localparam int SETTLE_MAIN = 1;
  localparam int NUM_OPS     = 5;

  typedef struct {
    logic [7:0] y;
    logic [2:0] sel;
    bit         last;
  } exp_t;

  logic       clk;
  logic       rst_n;
  int         cyc;
  int         n_checks;
  int         n_pass;
  bit         rand_ready;
  exp_t       exp_q[$];

  logic       cmd_valid, cmd_ready, cmd_sweep;
  logic [7:0] cmd_a, cmd_b, alu_a, alu_b, alu_y, rsp_y;
  logic [2:0] cmd_sel, alu_sel, rsp_sel;
  logic       rsp_valid, rsp_ready, rsp_last, busy;

  logic       s3_cmd_valid, s3_cmd_ready, s3_cmd_sweep;
  logic [7:0] s3_cmd_a, s3_cmd_b, s3_alu_a, s3_alu_b, s3_alu_y, s3_rsp_y;
  logic [2:0] s3_cmd_sel, s3_alu_sel, s3_rsp_sel;
  logic       s3_rsp_valid, s3_rsp_ready, s3_rsp_last, s3_busy;

  // ALU stubs: y = a + b + sel (mod 256)
  assign alu_y    = alu_a + alu_b + 8'(alu_sel);
  assign s3_alu_y = s3_alu_a + s3_alu_b + 8'(s3_alu_sel);

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .NUM_OPS(NUM_OPS), .SETTLE(SETTLE_MAIN)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .cmd_sel(cmd_sel), .cmd_sweep(cmd_sweep),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel), .alu_y(alu_y),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_y(rsp_y), .rsp_sel(rsp_sel),
    .rsp_last(rsp_last), .busy(busy)
  );

  alu_cmd_sequencer #(.WIDTH(8), .SEL_W(3), .NUM_OPS(NUM_OPS), .SETTLE(3)) u_dut_s3 (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(s3_cmd_valid), .cmd_ready(s3_cmd_ready), .cmd_a(s3_cmd_a), .cmd_b(s3_cmd_b),
    .cmd_sel(s3_cmd_sel), .cmd_sweep(s3_cmd_sweep),
    .alu_a(s3_alu_a), .alu_b(s3_alu_b), .alu_sel(s3_alu_sel), .alu_y(s3_alu_y),
    .rsp_valid(s3_rsp_valid), .rsp_ready(s3_rsp_ready), .rsp_y(s3_rsp_y), .rsp_sel(s3_rsp_sel),
    .rsp_last(s3_rsp_last), .busy(s3_busy)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
  endtask

  function automatic logic [7:0] alu_ref(input int a, input int b, input int sel);
    return 8'((a + b + sel) % 256);
  endfunction

  // Reference model: one expected response per opcode the command visits.
  task automatic issue(input logic [7:0] a, input logic [7:0] b, input logic [2:0] sel,
                       input bit sweep);
    int n = 0;
    exp_t e;
    while (!cmd_ready && n < 2000) begin
      @(posedge clk); #1;
      n++;
    end
    check("cmd_ready_wait", cmd_ready, 1'b1);
    if (sweep) begin
      for (int s = 0; s < NUM_OPS; s++) begin
        e.y = alu_ref(a, b, s);
        e.sel = 3'(s);
        e.last = (s == NUM_OPS - 1);
        exp_q.push_back(e);
      end
    end else begin
      e.y = alu_ref(a, b, sel);
      e.sel = sel;
      e.last = 1'b1;
      exp_q.push_back(e);
    end
    cmd_a = a;
    cmd_b = b;
    cmd_sel = sel;
    cmd_sweep = sweep;
    cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while (!(cmd_ready && exp_q.size() == 0) && n < 4000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait", cmd_ready, 1'b1);
  endtask

  initial begin
    forever begin
      @(posedge clk); #1;
      if (rand_ready) rsp_ready = 1'($urandom_range(0, 1));
    end
  end

  // Monitor: a response must appear SETTLE edges after the edge that started
  // its op (accept or sweep-advance handshake) and match the queue head.
  int start_edge;
  bit shown;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
      shown = 1'b0;
    end else begin
      if (cmd_valid && cmd_ready) start_edge = cyc + 1;
      if (rsp_valid) begin
        if (exp_q.size() == 0) begin
          check("unexpected_rsp", rsp_valid, 1'b0);
        end else begin
          if (!shown) check("rsp_edge", cyc, start_edge + SETTLE_MAIN);
          check("rsp_y", rsp_y, exp_q[0].y);
          check("rsp_sel", rsp_sel, exp_q[0].sel);
          check("rsp_last", rsp_last, exp_q[0].last);
          shown = 1'b1;
          if (rsp_ready) begin
            if (!exp_q[0].last) start_edge = cyc + 1;
            void'(exp_q.pop_front());
            shown = 1'b0;
          end
        end
      end
    end
  end

  initial begin
    int n;
    n_checks = 0;
    n_pass = 0;
    rand_ready = 1'b0;
    rst_n = 1'b0;
    cmd_valid = 1'b1;
    cmd_a = 8'd33; cmd_b = 8'd44; cmd_sel = 3'd1; cmd_sweep = 1'b0;
    rsp_ready = 1'b0;
    s3_cmd_valid = 1'b1;
    s3_cmd_a = 8'd0; s3_cmd_b = 8'd0; s3_cmd_sel = 3'd0; s3_cmd_sweep = 1'b0;
    s3_rsp_ready = 1'b0;

    // Reset with a command pending: nothing accepted, all outputs 0
    repeat (3) @(posedge clk);
    #1;
    check("rst_alu_a", alu_a, 0);
    check("rst_alu_b", alu_b, 0);
    check("rst_alu_sel", alu_sel, 0);
    check("rst_rsp_y", rsp_y, 0);
    check("rst_rsp_sel", rsp_sel, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_rsp_last", rsp_last, 0);
    check("rst_busy", busy, 0);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_s3_cmd_ready", s3_cmd_ready, 0);
    rst_n = 1'b1;
    cmd_valid = 1'b0;
    s3_cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("post_rst_cmd_ready", cmd_ready, 1);
    check("post_rst_busy", busy, 0);

    // Single op: 25 + 60 + 2 = 87 at E1, idle again at E2
    rsp_ready = 1'b1;
    issue(8'd25, 8'd60, 3'd2, 1'b0);
    @(posedge clk); #1;
    check("single_valid_e1", rsp_valid, 1);
    check("single_y_e1", rsp_y, 87);
    check("single_busy_e1", busy, 1);
    check("single_cmd_ready_e1", cmd_ready, 0);
    @(posedge clk); #1;
    check("single_cmd_ready_e2", cmd_ready, 1);

    // Full sweep at full rate: last response at E9, idle at E10
    issue(8'd10, 8'd50, 3'd6, 1'b1);
    repeat (9) @(posedge clk);
    #1;
    check("sweep_e9_y", rsp_y, 64);
    check("sweep_e9_last", rsp_last, 1);
    check("sweep_e9_cmd_ready", cmd_ready, 0);
    @(posedge clk); #1;
    check("sweep_e10_cmd_ready", cmd_ready, 1);

    // Backpressure on the second sweep response
    issue(8'd10, 8'd50, 3'd0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      @(posedge clk); #1;
      check("bp_valid", rsp_valid, 1);
      check("bp_y", rsp_y, 61);
      check("bp_sel", rsp_sel, 1);
      check("bp_alu_sel", alu_sel, 1);
      check("bp_cmd_ready", cmd_ready, 0);
    end
    rsp_ready = 1'b1;
    wait_idle();

    // Settle of 3 with 8-bit wrap; a second command during DRIVE is ignored
    s3_cmd_a = 8'd200; s3_cmd_b = 8'd100; s3_cmd_sel = 3'd0; s3_cmd_sweep = 1'b0;
    check("s3_ready_idle", s3_cmd_ready, 1);
    s3_cmd_valid = 1'b1;
    @(posedge clk); #1;
    s3_cmd_a = 8'd7; s3_cmd_b = 8'd7; s3_cmd_sel = 3'd1;
    check("s3_drive_cmd_ready", s3_cmd_ready, 0);
    check("s3_drive_busy", s3_busy, 1);
    n = 0;
    while (!s3_rsp_valid && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check("s3_settle_edges", n, 3);
    check("s3_rsp_y", s3_rsp_y, 44);
    check("s3_rsp_sel", s3_rsp_sel, 0);
    check("s3_rsp_last", s3_rsp_last, 1);
    check("s3_alu_a_held", s3_alu_a, 200);
    s3_cmd_valid = 1'b0;
    s3_rsp_ready = 1'b1;
    @(posedge clk); #1;
    check("s3_cmd_ready_after", s3_cmd_ready, 1);
    s3_rsp_ready = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    check("s3_no_second_rsp", s3_rsp_valid, 0);
    check("s3_idle_busy", s3_busy, 0);

    // Randomized commands with random response backpressure
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) begin
      issue(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)),
            3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
    end
    wait_idle();
    rand_ready = 1'b0;
    @(posedge clk); #1;
    rsp_ready = 1'b1;

    // Reset while the third sweep response is held
    issue(8'd10, 8'd50, 3'd0, 1'b1);
    repeat (4) @(posedge clk);
    #1;
    rsp_ready = 1'b0;
    @(posedge clk); #1;
    check("midrst_third_valid", rsp_valid, 1);
    check("midrst_third_sel", rsp_sel, 2);
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("midrst_rsp_valid", rsp_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_alu_a", alu_a, 0);
    check("midrst_cmd_ready", cmd_ready, 0);
    rst_n = 1'b1;
    rsp_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    check("after_rst_no_rsp", rsp_valid, 0);
    check("after_rst_busy", busy, 0);
    check("after_rst_cmd_ready", cmd_ready, 1);
    issue(8'd1, 8'd1, 3'd0, 1'b0);
    @(posedge clk); #1;
    check("after_rst_y", rsp_y, 2);
    wait_idle();

    check("queue_drained", exp_q.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
